// File: rtl/amdc_axil_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite register slave.
// Optional byte-lane write masking is enabled with AXIL_WSTRB_EN.
package amdc_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/amdc_axil_reg_bank.sv
// Register array with byte-enable write port, read mux (RW regs + status word) and write pulses.
// AXIL_WSTRB_EN: when defined, write strobes gate byte lanes; otherwise full words are written.
module amdc_axil_reg_bank
  import amdc_axil_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 3,
  parameter int NUM_RW_REGS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_en,
  input  logic [IDX_W-1:0]            i_wr_idx,
  input  logic [DATA_W-1:0]           i_wr_data,
  input  logic [DATA_W/8-1:0]         i_wr_strb,
  output logic [1:0]                  o_wr_resp,
  input  logic [IDX_W-1:0]            i_rd_idx,
  input  logic [DATA_W-1:0]           i_status,
  output logic [DATA_W-1:0]           o_rd_data,
  output logic [1:0]                  o_rd_resp,
  output logic [NUM_RW_REGS*DATA_W-1:0] o_reg_out,
  output logic [NUM_RW_REGS-1:0]      o_wr_pulse
);

  localparam logic [IDX_W:0] NUM_RW = (IDX_W+1)'(NUM_RW_REGS);

  logic [DATA_W-1:0]      r_regs [NUM_RW_REGS];
  logic [NUM_RW_REGS-1:0] r_wr_pulse;
  logic [DATA_W/8-1:0]    w_be;

`ifdef AXIL_WSTRB_EN
  assign w_be = i_wr_strb;
`else
  logic w_unused_strb;
  assign w_be          = '1;
  assign w_unused_strb = ^i_wr_strb;
`endif

  // The status word and everything above it are not writable.
  assign o_wr_resp = ({1'b0, i_wr_idx} < NUM_RW) ? RESP_OKAY : RESP_SLVERR;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_RW_REGS; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        r_wr_pulse[i] <= i_wr_en && (i_wr_idx == IDX_W'(i));
        if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
          for (int k = 0; k < DATA_W/8; k++) begin
            if (w_be[k]) r_regs[i][k*8 +: 8] <= i_wr_data[k*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    o_rd_resp = RESP_SLVERR;
    if ({1'b0, i_rd_idx} == NUM_RW) begin
      o_rd_data = i_status;
      o_rd_resp = RESP_OKAY;
    end
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if (i_rd_idx == IDX_W'(i)) begin
        o_rd_data = r_regs[i];
        o_rd_resp = RESP_OKAY;
      end
    end
  end

  for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_flat
    assign o_reg_out[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign o_wr_pulse = r_wr_pulse;

endmodule

// File: rtl/amdc_axil_reg_slave.sv
// AXI4-Lite slave: independent AW/W capture, one write outstanding, single-beat reads.
// Byte-lane masking of writes is controlled by the AXIL_WSTRB_EN macro (see reg bank).
module amdc_axil_reg_slave
  import amdc_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_RW_REGS        = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_RW_REGS-1:0]                 reg_wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          status_in,
  output logic [1:0]                             o_dbg_wr_state,
  output logic                                   o_dbg_rd_state
);

  // Handshake rule on every channel: a transfer happens on a rising ACLK edge where
  // VALID and READY are both 1; VALID, once raised, holds with its payload until then.

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int IDX_W = AW - 2;

  wr_state_t        r_wr_state, w_wr_state_n;
  rd_state_t        r_rd_state, w_rd_state_n;
  logic             r_awready, w_awready_n, r_wready, w_wready_n;
  logic             r_aw_held, w_aw_held_n, r_w_held, w_w_held_n;
  logic             r_bvalid, w_bvalid_n;
  logic [1:0]       r_bresp, w_bresp_n;
  logic             r_arready, w_arready_n, r_rvalid, w_rvalid_n;
  logic [DW-1:0]    r_rdata, w_rdata_n;
  logic [1:0]       r_rresp, w_rresp_n;
  logic [IDX_W-1:0] r_aw_idx;
  logic [DW-1:0]    r_wdata;
  logic [DW/8-1:0]  r_wstrb;
  logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [DW-1:0]    w_bank_rd_data;
  logic [1:0]       w_bank_rd_resp, w_bank_wr_resp;
  logic             w_unused;

  assign w_aw_hs  = S_AXI_AWVALID && r_awready;
  assign w_w_hs   = S_AXI_WVALID && r_wready;
  assign w_ar_hs  = S_AXI_ARVALID && r_arready;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  amdc_axil_reg_bank #(
    .DATA_W      (DW),
    .IDX_W       (IDX_W),
    .NUM_RW_REGS (NUM_RW_REGS)
  ) u_bank (
    .i_clk      (ACLK),
    .i_rst      (ARESET),
    .i_wr_en    (w_commit),
    .i_wr_idx   (r_aw_idx),
    .i_wr_data  (r_wdata),
    .i_wr_strb  (r_wstrb),
    .o_wr_resp  (w_bank_wr_resp),
    .i_rd_idx   (S_AXI_ARADDR[AW-1:2]),
    .i_status   (status_in),
    .o_rd_data  (w_bank_rd_data),
    .o_rd_resp  (w_bank_rd_resp),
    .o_reg_out  (reg_out),
    .o_wr_pulse (reg_wr_pulse)
  );

  always_comb begin
    w_wr_state_n = r_wr_state;
    w_awready_n  = r_awready;
    w_wready_n   = r_wready;
    w_aw_held_n  = r_aw_held;
    w_w_held_n   = r_w_held;
    w_bvalid_n   = r_bvalid;
    w_bresp_n    = r_bresp;
    w_commit     = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        // Readies come up out of reset here and fall once their half is captured.
        w_aw_held_n = r_aw_held || w_aw_hs;
        w_w_held_n  = r_w_held || w_w_hs;
        w_awready_n = !w_aw_held_n;
        w_wready_n  = !w_w_held_n;
        if (w_aw_held_n && w_w_held_n) w_wr_state_n = W_COMMIT;
      end
      W_COMMIT: begin
        w_commit     = (w_bank_wr_resp == RESP_OKAY);
        w_bvalid_n   = 1'b1;
        w_bresp_n    = w_bank_wr_resp;
        w_aw_held_n  = 1'b0;
        w_w_held_n   = 1'b0;
        w_wr_state_n = W_RESP;
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_bvalid_n   = 1'b0;
          w_awready_n  = 1'b1;
          w_wready_n   = 1'b1;
          w_wr_state_n = W_IDLE;
        end
      end
      default: w_wr_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_state <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      r_wr_state <= w_wr_state_n;
      r_awready  <= w_awready_n;
      r_wready   <= w_wready_n;
      r_aw_held  <= w_aw_held_n;
      r_w_held   <= w_w_held_n;
      r_bvalid   <= w_bvalid_n;
      r_bresp    <= w_bresp_n;
      if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[AW-1:2];
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
    end
  end

  always_comb begin
    w_rd_state_n = r_rd_state;
    w_arready_n  = r_arready;
    w_rvalid_n   = r_rvalid;
    w_rdata_n    = r_rdata;
    w_rresp_n    = r_rresp;
    case (r_rd_state)
      R_IDLE: begin
        w_arready_n = 1'b1;
        if (w_ar_hs) begin
          w_arready_n  = 1'b0;
          w_rvalid_n   = 1'b1;
          w_rdata_n    = w_bank_rd_data;
          w_rresp_n    = w_bank_rd_resp;
          w_rd_state_n = R_RESP;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          w_rvalid_n   = 1'b0;
          w_arready_n  = 1'b1;
          w_rd_state_n = R_IDLE;
        end
      end
      default: w_rd_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_state_n;
      r_arready  <= w_arready_n;
      r_rvalid   <= w_rvalid_n;
      r_rdata    <= w_rdata_n;
      r_rresp    <= w_rresp_n;
    end
  end

  assign S_AXI_AWREADY  = r_awready;
  assign S_AXI_WREADY   = r_wready;
  assign S_AXI_BVALID   = r_bvalid;
  assign S_AXI_BRESP    = r_bresp;
  assign S_AXI_ARREADY  = r_arready;
  assign S_AXI_RVALID   = r_rvalid;
  assign S_AXI_RDATA    = r_rdata;
  assign S_AXI_RRESP    = r_rresp;
  assign o_dbg_wr_state = r_wr_state;
  assign o_dbg_rd_state = r_rd_state;

endmodule

// File: doc/amdc_axil_reg_slave.md
Name: amdc_axil_reg_slave

Overview:
AXI4-Lite responder (slave) exposing a small register bank to the PS/interconnect. It is the target side of the AXI4-Lite master transactions issued by the team's VIP benches. It latches write address and data independently, commits writes, and returns B and R responses with full VALID/READY backpressure. Registers drive fabric logic; one extra read-only word samples a fabric status input.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width in bits; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; word index is addr[ADDR_W-1:2].
NUM_RW_REGS, 4, number of read/write registers, at word indices 0..NUM_RW_REGS-1.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  DATA_W  write data
S_AXI_WSTRB  in  DATA_W/8  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  DATA_W  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
reg_out  out  NUM_RW_REGS*DATA_W  flat register contents; reg i occupies bits [i*32+:32]
reg_wr_pulse  out  NUM_RW_REGS  one-cycle pulse on the cycle after reg i is committed
status_in  in  DATA_W  read-only word at index NUM_RW_REGS

Behaviour:
- Reset (async assert, sync release): all registers 0. All READY and VALID outputs 0. BRESP/RRESP 0, RDATA 0, reg_wr_pulse 0. A reset mid-transaction abandons it with no response.
- All outputs are registered. AWREADY, WREADY and ARREADY rise on the first clock edge after ARESET deasserts.
- Write FSM has three states: W_IDLE, W_COMMIT and W_RESP.
  - W_IDLE: AWREADY=1 until AW is captured; WREADY=1 until W is captured. AW and W may arrive in either order, or in the same cycle. Each ready drops the cycle after its handshake.
  - When both are held, go to W_COMMIT.
  - W_COMMIT (1 cycle): decode the index. In range: update the register and set BRESP=OKAY (2'b00). Out of range or the RO index: no update, BRESP=SLVERR (2'b10). Go to W_RESP with BVALID=1.
  - W_RESP: hold BVALID/BRESP until BREADY. Then go to W_IDLE, with both readies high the next cycle.
  - Only one write is outstanding at a time. Minimum AW+W-to-BVALID latency is 2 cycles.
- Read FSM has two states: R_IDLE and R_RESP.
  - R_IDLE: ARREADY=1. On handshake, register RDATA/RRESP from the current register contents and go to R_RESP with RVALID=1 the next cycle (1-cycle latency).
  - Index < NUM_RW_REGS: register value, OKAY. Index == NUM_RW_REGS: status_in sampled at the AR handshake, OKAY. Otherwise: RDATA=0, SLVERR.
  - R_RESP: hold RVALID/RDATA/RRESP stable until RREADY. Then return to R_IDLE, with ARREADY high the next cycle.
- Read and write paths are independent and run concurrently. If an AR handshake coincides with W_COMMIT to the same register, RDATA returns the old value.
- Address bits [1:0] are ignored. Upper address bits above the index width wrap; there is no alias check beyond the index range.
- reg_wr_pulse asserts only for in-range OKAY writes. It asserts even when the strobe mask is all-zero.

Optional Feature:
AXIL_WSTRB_EN:
- Defined: each byte lane k updates only if WSTRB[k]=1.
- Undefined: WSTRB is ignored and the full 32-bit word is written.
- BRESP and reg_wr_pulse behave the same either way.

Decomposition:
- Package amdc_axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10; enum wr_state_t {W_IDLE, W_COMMIT, W_RESP}; enum rd_state_t {R_IDLE, R_RESP}.
- One sub-module, amdc_axil_reg_bank: register array with byte-enable write port, read mux and write pulses.
- The AXI handshake FSMs stay in the top module.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x00/0x04/0x08/0x0C, then read back -> each BRESP=OKAY, RDATA 0x1..0x4, reg_wr_pulse[i] pulses once each.
- W presented 3 cycles before AW (data 0xDEADBEEF to 0x04) -> single commit, reg_out[63:32]=0xDEADBEEF, one BVALID.
- Hold BREADY=0 for 5 cycles after BVALID -> BVALID/BRESP stable, AWREADY/WREADY stay 0 until the B handshake.
- status_in=0xA5A5_0000, read 0x10 -> RDATA=0xA5A50000, OKAY. Write 0x10 -> SLVERR, status unchanged. Read 0x14 -> SLVERR, RDATA 0.
- With AXIL_WSTRB_EN: reg0=0x11223344, write 0xFFFFFFFF with WSTRB=4'b0101 -> reg0=0x11FF33FF. Without the macro -> 0xFFFFFFFF.
- Assert ARESET between AW handshake and W -> all outputs 0, no BVALID. After release, a fresh write/read to 0x08 completes normally.
